// File: rtl/mesh_pkt_pkg.sv
// rtl/mesh_pkt_pkg.sv - mesh packet field layout, receive FSM states and destination match
package mesh_pkt_pkg;

    localparam int PCKG_SZ     = 40;
    localparam int NXTJP_MSB   = PCKG_SZ - 1;
    localparam int NXTJP_LSB   = PCKG_SZ - 8;
    localparam int ROW_MSB     = PCKG_SZ - 9;
    localparam int ROW_LSB     = PCKG_SZ - 12;
    localparam int COL_MSB     = PCKG_SZ - 13;
    localparam int COL_LSB     = PCKG_SZ - 16;
    localparam int MODE_BIT    = PCKG_SZ - 17;
    localparam int PAYLOAD_MSB = PCKG_SZ - 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } rx_state_e;

    // The mode bit plays no part in routing, so it is deliberately not examined here.
    function automatic logic dest_match(
        input logic [PCKG_SZ-1:0] pkt,
        input logic [3:0]         my_row,
        input logic [3:0]         my_col,
        input logic [7:0]         bdcst
    );
        return ((pkt[ROW_MSB:ROW_LSB] == my_row) && (pkt[COL_MSB:COL_LSB] == my_col))
            || (pkt[NXTJP_MSB:NXTJP_LSB] == bdcst);
    endfunction

endpackage

// File: rtl/mesh_term_rx_if.sv
// rtl/mesh_term_rx_if.sv - router-side drain and consumer-side valid/ready signals of the terminal sink
interface mesh_term_rx_if #(
    parameter int PCKG_SZ = 40
);
    logic               pndng;
    logic [PCKG_SZ-1:0] data_out;
    logic               pop;
    logic               rx_valid;
    logic [PCKG_SZ-1:0] rx_data;
    logic               rx_err;
    logic               rx_ready;

    modport master (
        output pndng, data_out, rx_ready,
        input  pop, rx_valid, rx_data, rx_err
    );

    modport slave (
        input  pndng, data_out, rx_ready,
        output pop, rx_valid, rx_data, rx_err
    );
endinterface

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous first-word-fall-through FIFO holding {err, packet} entries
module rx_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;

    // A read in the same cycle frees a slot, so a write to a full FIFO is accepted then.
    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/mesh_term_rx.sv
// rtl/mesh_term_rx.sv - mesh terminal receive sink: drains the router, checks destination, buffers and counts
module mesh_term_rx
    import mesh_pkt_pkg::*;
#(
    parameter int         pckg_sz  = PCKG_SZ,
    parameter logic [3:0] MY_ROW   = 4'd0,
    parameter logic [3:0] MY_COL   = 4'd0,
    parameter logic [7:0] bdcst    = {8{1'b1}},
    parameter int         RX_DEPTH = 4,
    parameter int         CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    mesh_term_rx_if.slave      bus,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               full
);
    localparam int CWF = $clog2(RX_DEPTH) + 1;

    rx_state_e          r_state;
    logic               r_pop;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic [CWF-1:0]     w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_rd;
    logic               w_wr;
    logic               w_err;
    logic               w_room;
    logic [pckg_sz:0]   w_head;

    assign w_rd   = bus.rx_ready && !w_empty;
    assign w_wr   = (r_state == POP);
    assign w_err  = !dest_match(bus.data_out, MY_ROW, MY_COL, bdcst);
    // Room next cycle: not full now, or the consumer is taking the head this cycle.
    assign w_room = (w_count != CWF'(RX_DEPTH)) || w_rd;

    rx_fifo #(
        .WIDTH (pckg_sz + 1),
        .DEPTH (RX_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr),
        .i_wr_data ({w_err, bus.data_out}),
        .i_rd_en   (bus.rx_ready),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign bus.pop      = r_pop;
    assign bus.rx_valid = !w_empty;
    assign bus.rx_data  = w_head[pckg_sz-1:0];
    assign bus.rx_err   = w_head[pckg_sz];
    assign pkt_cnt      = r_pkt_cnt;
    assign err_cnt      = r_err_cnt;
    assign full         = w_full;

    // SETTLE gives the router one cycle to advance its head before pndng is trusted again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pop     <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.pndng && w_room) begin
                        r_state <= POP;
                        r_pop   <= 1'b1;
                    end
                end
                POP: begin
                    r_state <= SETTLE;
                    r_pop   <= 1'b0;
                    if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                    if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                SETTLE: begin
                    r_state <= IDLE;
                    r_pop   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_pop   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_term_rx.sv
// tb/tb_mesh_term_rx.sv - randomized bench for mesh_term_rx against a queue-based router/FIFO model
module tb_mesh_term_rx;
    localparam int PW    = 40;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;
    logic full;

    always #5 clk = ~clk;

    mesh_term_rx_if #(.PCKG_SZ(PW)) bus();

    mesh_term_rx #(
        .pckg_sz(PW), .MY_ROW(4'd2), .MY_COL(4'd0), .bdcst(8'hFF),
        .RX_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .full(full)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [PW-1:0] rq[$];
    logic [PW:0]   mq[$];
    int  m_pkt, m_err, cyc, last_pop, stall, n_pops;
    int  pop_cycs[$];
    bit  mon_en, obs_pop, obs_hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [PW-1:0] p);
        int nx, row, col;
        nx  = int'(p[39:32]);
        row = int'(p[31:28]);
        col = int'(p[27:24]);
        return !((nx == 255) || (row == 2 && col == 0));
    endfunction

    task drive_router();
        bus.pndng    = (rq.size() != 0);
        bus.data_out = (rq.size() != 0) ? rq[0] : '0;
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [7:0] nx;
        logic [3:0] row, col;
        nx  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        row = 4'($urandom_range(0, 3));
        col = 4'($urandom_range(0, 1));
        return {nx, row, col, 1'($urandom_range(0, 1)), 23'($urandom)};
    endfunction

    // Observe mid-cycle: compare DUT against the model and log what the coming edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("rx_valid", bus.rx_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("rx_data", bus.rx_data, mq[0][PW-1:0]);
                check("rx_err", bus.rx_err, mq[0][PW]);
            end else begin
                check("rx_data_empty", bus.rx_data, 0);
                check("rx_err_empty", bus.rx_err, 0);
            end
            check("full", full, mq.size() == DEPTH);
            check("pkt_cnt", pkt_cnt, m_pkt);
            check("err_cnt", err_cnt, m_err);
            if (bus.pop) begin
                check("pop_pndng", bus.pndng, 1);
                check("pop_room", mq.size() < DEPTH, 1);
                check("pop_gap", (cyc - last_pop) >= 3, 1);
                last_pop = cyc;
                pop_cycs.push_back(cyc);
                stall = 0;
            end else if (bus.pndng && mq.size() < DEPTH) begin
                stall++;
                check("pop_stall", stall <= 2, 1);
            end else begin
                stall = 0;
            end
            obs_pop = bus.pop;
            obs_hs  = bus.rx_valid && bus.rx_ready;
        end
    end

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (obs_pop && rq.size() != 0) begin
                mq.push_back({exp_err(rq[0]), rq[0]});
                if (m_pkt < CMAX) m_pkt++;
                if (exp_err(rq[0]) && m_err < CMAX) m_err++;
                n_pops++;
                void'(rq.pop_front());
            end
            if (obs_hs && mq.size() != 0) void'(mq.pop_front());
            drive_router();
        end
        obs_pop = 1'b0;
        obs_hs  = 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input logic [PW-1:0] p);
        rq.push_back(p);
        drive_router();
    endtask

    task automatic clear_model();
        mq.delete();
        pop_cycs.delete();
        m_pkt = 0; m_err = 0; stall = 0; last_pop = -100;
        obs_pop = 1'b0; obs_hs = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.rx_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!bus.rx_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic consume_one();
        step(1);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
    endtask

    logic [PW-1:0] pkt0;
    int k;

    initial begin
        reset = 1'b0; mon_en = 1'b0; cyc = 0; n_pops = 0;
        bus.pndng = 1'b0; bus.data_out = '0; bus.rx_ready = 1'b0;
        clear_model();
        pkt0 = {8'h00, 4'h2, 4'h0, 1'b1, 23'h1};
        push_pkt(pkt0);

        step(3);
        check("rst_pop", bus.pop, 0);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_full", full, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_err", bus.rx_err, 0);

        reset = 1'b1; mon_en = 1'b1;
        @(negedge clk); check("lat_idle", bus.pop, 0);
        @(negedge clk); check("lat_pop", bus.pop, 1);
        @(negedge clk);
        check("lat_valid", bus.rx_valid, 1);
        check("lat_pop_drop", bus.pop, 0);
        check("m1_data", bus.rx_data, pkt0);
        check("m1_err", bus.rx_err, 0);
        check("m1_pkt_cnt", pkt_cnt, 1);
        check("m1_err_cnt", err_cnt, 0);
        consume_one();

        push_pkt({8'h00, 4'h3, 4'h1, 1'b0, 23'h5A5A});
        wait_valid("mis", 20);
        check("mis_err", bus.rx_err, 1);
        check("mis_err_cnt", err_cnt, 1);
        consume_one();

        push_pkt({8'hFF, 4'h3, 4'h1, 1'b0, 23'h77});
        wait_valid("bc", 20);
        check("bc_err", bus.rx_err, 0);
        check("bc_err_cnt", err_cnt, 1);
        consume_one();

        step(3);
        pop_cycs.delete();
        for (int i = 0; i < 6; i++) push_pkt(rand_pkt());
        step(25);
        check("bp_pops", pop_cycs.size(), 4);
        for (int i = 1; i < 4 && i < pop_cycs.size(); i++)
            check("bp_spacing", pop_cycs[i] - pop_cycs[i-1], 3);
        check("bp_full", full, 1);
        check("bp_pndng_held", bus.pndng, 1);

        pop_cycs.delete();
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
        step(12);
        check("bp_one_more", pop_cycs.size(), 1);
        check("bp_refull", full, 1);

        for (int i = 0; i < 500; i++) begin
            step(1);
            if ($urandom_range(0, 2) == 0 && rq.size() < 3) push_pkt(rand_pkt());
            bus.rx_ready = 1'($urandom_range(0, 1));
        end
        bus.rx_ready = 1'b1;
        step(20);
        check("sat_enough_pops", n_pops > CMAX + 5, 1);
        check("sat_pkt_cnt", pkt_cnt, CMAX);

        push_pkt(rand_pkt());
        k = 0;
        @(negedge clk);
        while (!bus.pop && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("midpop_seen", bus.pop, 1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("midrst_pop", bus.pop, 0);
        check("midrst_valid", bus.rx_valid, 0);
        check("midrst_full", full, 0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        clear_model();
        check("midrst_pkt_kept", rq.size() != 0, 1);
        step(2);
        reset = 1'b1; mon_en = 1'b1;
        step(20);
        check("post_rst_pkt_cnt", pkt_cnt, 1);
        check("post_rst_drained", bus.pndng, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
